id_ex_stage_reg: RTL and testbench

- Pipeline register between decode (control decoder plus register file read) and execute in the MIPS pipeline.
- Captures the decoded control bundle, operands, immediate, register specifiers and PC+4 each cycle.
- Supports a hold (stall) for back-pressure and a flush that inserts a bubble for load-use hazards and branch/jump redirects.
- Keeps a saturating count of inserted bubbles for performance debug.

---
 rtl/id_ex_stage_reg_pkg.sv | 37 +++
 rtl/id_ex_stage_reg_pipe_reg_en_clr.sv | 30 +++
 rtl/id_ex_stage_reg.sv | 124 ++++++++++++
 tb/tb_id_ex_stage_reg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared MIPS decode definitions for the ID/EX pipeline register: opcodes,
// ALUOp classes and the layout of the registered control bundle.
package id_ex_stage_reg_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_e;

   localparam int CTRL_W = 10;

   localparam int CTRL_REGDST   = 9;
   localparam int CTRL_ALUSRC   = 8;
   localparam int CTRL_MEMTOREG = 7;
   localparam int CTRL_REGWRITE = 6;
   localparam int CTRL_MEMREAD  = 5;
   localparam int CTRL_MEMWRITE = 4;
   localparam int CTRL_BRANCH   = 3;
   localparam int CTRL_JUMP     = 2;
   localparam int CTRL_ALUOP_HI = 1;
   localparam int CTRL_ALUOP_LO = 0;

   // An empty decode slot must never carry side-effecting control into execute.
   function automatic logic [CTRL_W-1:0] ctrl_gate(input logic [CTRL_W-1:0] ctrl,
                                                   input logic valid);
      return valid ? ctrl : '0;
   endfunction

endpackage

// File: rtl/id_ex_stage_reg_pipe_reg_en_clr.sv
// Generic pipeline register with async reset, synchronous clear and load enable.
// Clear beats hold so a flush can overwrite a stalled stage.
module pipe_reg_en_clr
   import id_ex_stage_reg_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else if (clr) begin
         q_q <= '0;
      end else if (en) begin
         q_q <= d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: control bundle plus valid, data payload, and a
// saturating count of bubbles entering execute.
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_RegDst,
   input  logic              in_ALUSrc,
   input  logic              in_MemToReg,
   input  logic              in_RegWrite,
   input  logic              in_MemRead,
   input  logic              in_MemWrite,
   input  logic              in_Branch,
   input  logic              in_Jump,
   input  logic [1:0]        in_ALUOp,
   input  logic [DATA_W-1:0] in_pc4,
   input  logic [DATA_W-1:0] in_rs_data,
   input  logic [DATA_W-1:0] in_rt_data,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [REG_W-1:0]  in_rs,
   input  logic [REG_W-1:0]  in_rt,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [5:0]        in_funct,
   output logic              out_valid,
   output logic              out_RegDst,
   output logic              out_ALUSrc,
   output logic              out_MemToReg,
   output logic              out_RegWrite,
   output logic              out_MemRead,
   output logic              out_MemWrite,
   output logic              out_Branch,
   output logic              out_Jump,
   output logic [1:0]        out_ALUOp,
   output logic [DATA_W-1:0] out_pc4,
   output logic [DATA_W-1:0] out_rs_data,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [DATA_W-1:0] out_imm,
   output logic [REG_W-1:0]  out_rs,
   output logic [REG_W-1:0]  out_rt,
   output logic [REG_W-1:0]  out_rd,
   output logic [5:0]        out_funct,
   output logic [CNT_W-1:0]  bubble_count
);

   localparam int PAY_W = 4 * DATA_W + 3 * REG_W + 6;

   logic [CTRL_W-1:0] in_ctrl;
   logic [CTRL_W:0]   ctrl_d;
   logic [CTRL_W:0]   ctrl_q;
   logic [PAY_W-1:0]  pay_d;
   logic [PAY_W-1:0]  pay_q;
   logic              load_en;

   assign in_ctrl = {in_RegDst, in_ALUSrc, in_MemToReg, in_RegWrite, in_MemRead,
                     in_MemWrite, in_Branch, in_Jump, in_ALUOp};
   assign ctrl_d  = {in_valid, ctrl_gate(in_ctrl, in_valid)};
   assign pay_d   = {in_pc4, in_rs_data, in_rt_data, in_imm, in_rs, in_rt, in_rd, in_funct};
   assign load_en = ~stall;

   pipe_reg_en_clr #(.W(CTRL_W + 1)) u_ctrl_reg (
      .clk   (clk),
      .reset (reset),
      .en    (load_en),
      .clr   (flush),
      .d     (ctrl_d),
      .q     (ctrl_q)
   );

   pipe_reg_en_clr #(.W(PAY_W)) u_data_reg (
      .clk   (clk),
      .reset (reset),
      .en    (load_en),
      .clr   (flush),
      .d     (pay_d),
      .q     (pay_q)
   );

   assign out_valid    = ctrl_q[CTRL_W];
   assign out_RegDst   = ctrl_q[CTRL_REGDST];
   assign out_ALUSrc   = ctrl_q[CTRL_ALUSRC];
   assign out_MemToReg = ctrl_q[CTRL_MEMTOREG];
   assign out_RegWrite = ctrl_q[CTRL_REGWRITE];
   assign out_MemRead  = ctrl_q[CTRL_MEMREAD];
   assign out_MemWrite = ctrl_q[CTRL_MEMWRITE];
   assign out_Branch   = ctrl_q[CTRL_BRANCH];
   assign out_Jump     = ctrl_q[CTRL_JUMP];
   assign out_ALUOp    = ctrl_q[CTRL_ALUOP_HI:CTRL_ALUOP_LO];

   assign {out_pc4, out_rs_data, out_rt_data, out_imm,
           out_rs, out_rt, out_rd, out_funct} = pay_q;

   // A bubble enters execute on any flush, or on an unstalled load of an empty slot.
   logic [CNT_W-1:0] bubble_q;
   logic [CNT_W-1:0] bubble_d;
   logic             bubble_inc;

   assign bubble_inc = flush | (~stall & ~in_valid);

   always_comb begin
      bubble_d = bubble_q;
      if (bubble_inc && (bubble_q != {CNT_W{1'b1}})) begin
         bubble_d = bubble_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_q <= '0;
      end else begin
         bubble_q <= bubble_d;
      end
   end

   assign bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed vector bench for id_ex_stage_reg: table of per-edge stimulus and
// expected outputs, plus hand sequences for async reset and counter saturation.
module tb_id_ex_stage_reg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CNT_W  = 4;
   localparam int NVEC   = 13;

   // Control encodings, bit order RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp[1:0]
   localparam logic [9:0] C_LW   = 10'h1E0;
   localparam logic [9:0] C_R    = 10'h242;
   localparam logic [9:0] C_SW   = 10'h110;
   localparam logic [9:0] C_BEQ  = 10'h009;
   localparam logic [9:0] C_J    = 10'h004;
   localparam logic [9:0] C_ADDI = 10'h140;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        valid;
      logic [9:0]  ctrl;
      logic [31:0] pc4;
      logic [31:0] rsd;
      logic [31:0] rtd;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [5:0]  funct;
      logic        e_valid;
      logic [9:0]  e_ctrl;
      logic [31:0] e_pc4;
      logic [31:0] e_rsd;
      logic [31:0] e_rtd;
      logic [31:0] e_imm;
      logic [4:0]  e_rs;
      logic [4:0]  e_rt;
      logic [4:0]  e_rd;
      logic [5:0]  e_funct;
      logic [3:0]  e_bc;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset, stall, flush, in_valid;
   logic [9:0]        in_ctrl;
   logic [DATA_W-1:0] in_pc4, in_rs_data, in_rt_data, in_imm;
   logic [REG_W-1:0]  in_rs, in_rt, in_rd;
   logic [5:0]        in_funct;

   logic              out_valid, out_RegDst, out_ALUSrc, out_MemToReg, out_RegWrite;
   logic              out_MemRead, out_MemWrite, out_Branch, out_Jump;
   logic [1:0]        out_ALUOp;
   logic [DATA_W-1:0] out_pc4, out_rs_data, out_rt_data, out_imm;
   logic [REG_W-1:0]  out_rs, out_rt, out_rd;
   logic [5:0]        out_funct;
   logic [CNT_W-1:0]  bubble_count;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_RegDst    (in_ctrl[9]),
      .in_ALUSrc    (in_ctrl[8]),
      .in_MemToReg  (in_ctrl[7]),
      .in_RegWrite  (in_ctrl[6]),
      .in_MemRead   (in_ctrl[5]),
      .in_MemWrite  (in_ctrl[4]),
      .in_Branch    (in_ctrl[3]),
      .in_Jump      (in_ctrl[2]),
      .in_ALUOp     (in_ctrl[1:0]),
      .in_pc4       (in_pc4),
      .in_rs_data   (in_rs_data),
      .in_rt_data   (in_rt_data),
      .in_imm       (in_imm),
      .in_rs        (in_rs),
      .in_rt        (in_rt),
      .in_rd        (in_rd),
      .in_funct     (in_funct),
      .out_valid    (out_valid),
      .out_RegDst   (out_RegDst),
      .out_ALUSrc   (out_ALUSrc),
      .out_MemToReg (out_MemToReg),
      .out_RegWrite (out_RegWrite),
      .out_MemRead  (out_MemRead),
      .out_MemWrite (out_MemWrite),
      .out_Branch   (out_Branch),
      .out_Jump     (out_Jump),
      .out_ALUOp    (out_ALUOp),
      .out_pc4      (out_pc4),
      .out_rs_data  (out_rs_data),
      .out_rt_data  (out_rt_data),
      .out_imm      (out_imm),
      .out_rs       (out_rs),
      .out_rt       (out_rt),
      .out_rd       (out_rd),
      .out_funct    (out_funct),
      .bubble_count (bubble_count)
   );

   function automatic logic [163:0] actual_flat();
      return {out_valid, out_RegDst, out_ALUSrc, out_MemToReg, out_RegWrite, out_MemRead,
              out_MemWrite, out_Branch, out_Jump, out_ALUOp, out_pc4, out_rs_data,
              out_rt_data, out_imm, out_rs, out_rt, out_rd, out_funct, bubble_count};
   endfunction

   function automatic logic [163:0] expect_flat(input vec_t v);
      return {v.e_valid, v.e_ctrl, v.e_pc4, v.e_rsd, v.e_rtd, v.e_imm,
              v.e_rs, v.e_rt, v.e_rd, v.e_funct, v.e_bc};
   endfunction

   task automatic check_flat(input string name, input logic [163:0] exp_v);
      logic [163:0] act_v;
      act_v = actual_flat();
      n_vec++;
      if (act_v !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
      end else begin
         $display("ok   %s: %h", name, act_v);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_vec++;
      if (act_v !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
      end else begin
         $display("ok   %s: %0h", name, act_v);
      end
   endtask

   task automatic check_invariant(input string name);
      logic side;
      side = out_RegWrite | out_MemRead | out_MemWrite | out_Branch | out_Jump;
      n_vec++;
      if (!out_valid && side) begin
         n_bad++;
         $display("FAIL %s invariant: valid=0 with side-effect ctrl=%b expected 0", name, side);
      end
   endtask

   task automatic drive(input vec_t v);
      stall      = v.stall;
      flush      = v.flush;
      in_valid   = v.valid;
      in_ctrl    = v.ctrl;
      in_pc4     = v.pc4;
      in_rs_data = v.rsd;
      in_rt_data = v.rtd;
      in_imm     = v.imm;
      in_rs      = v.rs;
      in_rt      = v.rt;
      in_rd      = v.rd;
      in_funct   = v.funct;
   endtask

   vec_t vecs [NVEC];

   initial begin
      vecs[0]  = '{0,0,1,C_LW,  32'h104,32'h1000,32'hDEAD,32'h4,5'd9,5'd8,5'd0,6'h04,
                   1,C_LW,  32'h104,32'h1000,32'hDEAD,32'h4,5'd9,5'd8,5'd0,6'h04,4'd0};
      vecs[1]  = '{0,0,1,C_R,   32'h108,32'h5,32'h7,32'h1820,5'd1,5'd2,5'd3,6'h20,
                   1,C_R,   32'h108,32'h5,32'h7,32'h1820,5'd1,5'd2,5'd3,6'h20,4'd0};
      vecs[2]  = '{1,0,1,C_SW,  32'h10C,32'h2000,32'hBEEF,32'h8,5'd10,5'd11,5'd0,6'h08,
                   1,C_R,   32'h108,32'h5,32'h7,32'h1820,5'd1,5'd2,5'd3,6'h20,4'd0};
      vecs[3]  = '{1,0,1,C_BEQ, 32'h110,32'h1,32'h2,32'hFFFFFFFC,5'd1,5'd2,5'd31,6'h3C,
                   1,C_R,   32'h108,32'h5,32'h7,32'h1820,5'd1,5'd2,5'd3,6'h20,4'd0};
      vecs[4]  = '{1,0,0,C_LW,  32'h114,32'hAAAA,32'hBBBB,32'h10,5'd7,5'd6,5'd5,6'h10,
                   1,C_R,   32'h108,32'h5,32'h7,32'h1820,5'd1,5'd2,5'd3,6'h20,4'd0};
      vecs[5]  = '{0,0,1,C_SW,  32'h10C,32'h2000,32'hBEEF,32'h8,5'd10,5'd11,5'd0,6'h08,
                   1,C_SW,  32'h10C,32'h2000,32'hBEEF,32'h8,5'd10,5'd11,5'd0,6'h08,4'd0};
      vecs[6]  = '{1,1,1,C_SW,  32'h118,32'h3000,32'hCAFE,32'hC,5'd12,5'd13,5'd0,6'h0C,
                   0,10'h0, 32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,6'h00,4'd1};
      vecs[7]  = '{0,0,0,10'h050,32'h200,32'h11,32'h22,32'h33,5'd4,5'd5,5'd6,6'h33,
                   0,10'h0, 32'h200,32'h11,32'h22,32'h33,5'd4,5'd5,5'd6,6'h33,4'd2};
      vecs[8]  = '{1,0,0,10'h050,32'h300,32'h44,32'h55,32'h66,5'd7,5'd8,5'd9,6'h26,
                   0,10'h0, 32'h200,32'h11,32'h22,32'h33,5'd4,5'd5,5'd6,6'h33,4'd2};
      vecs[9]  = '{0,0,1,C_BEQ, 32'h124,32'h9,32'h9,32'hFFFFFFFC,5'd3,5'd4,5'd31,6'h3C,
                   1,C_BEQ, 32'h124,32'h9,32'h9,32'hFFFFFFFC,5'd3,5'd4,5'd31,6'h3C,4'd2};
      vecs[10] = '{0,0,1,C_J,   32'h128,32'h0,32'h0,32'h40,5'd0,5'd0,5'd0,6'h00,
                   1,C_J,   32'h128,32'h0,32'h0,32'h40,5'd0,5'd0,5'd0,6'h00,4'd2};
      vecs[11] = '{0,1,1,C_ADDI,32'h12C,32'h77,32'h88,32'h5,5'd14,5'd15,5'd0,6'h05,
                   0,10'h0, 32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,6'h00,4'd3};
      vecs[12] = '{0,0,1,C_LW,  32'h130,32'h1000,32'h0,32'h8,5'd9,5'd8,5'd0,6'h08,
                   1,C_LW,  32'h130,32'h1000,32'h0,32'h8,5'd9,5'd8,5'd0,6'h08,4'd3};

      reset = 1'b1;
      drive('{default: '0});
      #12;
      check_flat("reset_state", '0);

      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check_flat($sformatf("vec%0d", i), expect_flat(vecs[i]));
         check_invariant($sformatf("vec%0d", i));
         @(negedge clk);
      end

      // Asynchronous reset between edges while a valid RegWrite instruction is held.
      check_val("pre_reset_valid_regwrite", {30'd0, out_valid, out_RegWrite}, 32'd3);
      #2;
      reset = 1'b1;
      #1;
      check_flat("async_reset_no_edge", '0);

      @(negedge clk);
      reset = 1'b0;
      flush = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         check_val($sformatf("sat_bc_edge%0d", k), {28'd0, bubble_count},
                   (k + 1 > 15) ? 32'd15 : 32'(k + 1));
         check_invariant($sformatf("sat_edge%0d", k));
      end
      flush = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
